// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter (WB / mul-div / late-load) with a pending-write scoreboard.
// Define RF_WB_RR_EN for round-robin between mul/div and load; otherwise mul/div has fixed priority.
module rf_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_addr,
  input  logic [31:0] ld_data,
  input  logic        alloc_valid,
  input  logic [4:0]  alloc_addr,
  input  logic [4:0]  qa1,
  input  logic [4:0]  qa2,
  output logic        busy1,
  output logic        busy2,
  output logic [31:0] busy_mask,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd
);

  logic        md_take;
  logic        ld_take;
  logic        gnt_any;
  logic [4:0]  gnt_addr;
  logic [31:0] gnt_data;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_wa_q, rf_wa_d;
  logic [31:0] rf_wd_q, rf_wd_d;
  logic [31:0] busy_q, busy_d;

`ifdef RF_WB_RR_EN
  // rr_q=0 favours mul/div, rr_q=1 favours load; only consulted when both request.
  logic rr_q, rr_d;
`endif

  always_comb begin
    md_take = 1'b0;
    ld_take = 1'b0;
    if (!wb_valid) begin
`ifdef RF_WB_RR_EN
      if (md_valid && ld_valid) begin
        md_take = ~rr_q;
        ld_take = rr_q;
      end else begin
        md_take = md_valid;
        ld_take = ld_valid;
      end
`else
      md_take = md_valid;
      ld_take = ld_valid & ~md_valid;
`endif
    end
  end

  assign md_ready = md_take;
  assign ld_ready = ld_take;

  always_comb begin
    gnt_any  = wb_valid | md_take | ld_take;
    gnt_addr = ld_addr;
    gnt_data = ld_data;
    if (wb_valid) begin
      gnt_addr = wb_addr;
      gnt_data = wb_data;
    end else if (md_take) begin
      gnt_addr = md_addr;
      gnt_data = md_data;
    end
  end

  always_comb begin
    set_mask = 32'd0;
    clr_mask = 32'd0;
    if (alloc_valid)
      set_mask[alloc_addr] = 1'b1;
    if (md_take || ld_take)
      clr_mask[gnt_addr] = 1'b1;
    // Set after clear so a same-edge alloc of the register being retired keeps it busy.
    busy_d = ((busy_q & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
  end

  always_comb begin
    rf_we_d = gnt_any && (gnt_addr != 5'd0);
    rf_wa_d = rf_wa_q;
    rf_wd_d = rf_wd_q;
    if (gnt_any) begin
      rf_wa_d = gnt_addr;
      rf_wd_d = gnt_data;
    end
  end

`ifdef RF_WB_RR_EN
  always_comb begin
    rr_d = rr_q;
    if (md_take)
      rr_d = 1'b1;
    else if (ld_take)
      rr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rr_q <= 1'b0;
    else
      rr_q <= rr_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q <= 1'b0;
      rf_wa_q <= 5'd0;
      rf_wd_q <= 32'd0;
      busy_q  <= 32'd0;
    end else begin
      rf_we_q <= rf_we_d;
      rf_wa_q <= rf_wa_d;
      rf_wd_q <= rf_wd_d;
      busy_q  <= busy_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_wa     = rf_wa_q;
  assign rf_wd     = rf_wd_q;
  assign busy_mask = busy_q;
  assign busy1     = busy_q[qa1];
  assign busy2     = busy_q[qa2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios then randomized traffic vs. a reference model.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, md_valid, ld_valid, alloc_valid;
  logic [4:0]  wb_addr, md_addr, ld_addr, alloc_addr, qa1, qa2;
  logic [31:0] wb_data, md_data, ld_data;
  logic        md_ready, ld_ready, busy1, busy2, rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd, busy_mask;

  int checks = 0;
  int errors = 0;

  // Reference model state: scoreboard as a plain bit vector, expected write port, last served slow requester.
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int          m_last;
  int          last_g;
  int          grants[$];

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
    .qa1(qa1), .qa2(qa2), .busy1(busy1), .busy2(busy2), .busy_mask(busy_mask),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Who the spec says wins this cycle: 0=wb, 1=md, 2=ld, -1=none.
  function automatic int model_grant();
    if (wb_valid) return 0;
    if (md_valid && ld_valid) begin
`ifdef RF_WB_RR_EN
      return (m_last == 1) ? 2 : 1;
`else
      return 1;
`endif
    end
    if (md_valid) return 1;
    if (ld_valid) return 2;
    return -1;
  endfunction

  task automatic step(input string tag);
    int          g;
    logic [4:0]  a;
    logic [31:0] d;
    @(negedge clk);
    g = model_grant();
    chk({tag, ".md_ready"}, {31'd0, md_ready}, {31'd0, g == 1});
    chk({tag, ".ld_ready"}, {31'd0, ld_ready}, {31'd0, g == 2});
    chk({tag, ".busy1"}, {31'd0, busy1}, {31'd0, m_busy[qa1]});
    chk({tag, ".busy2"}, {31'd0, busy2}, {31'd0, m_busy[qa2]});
    a = (g == 0) ? wb_addr : (g == 1) ? md_addr : ld_addr;
    d = (g == 0) ? wb_data : (g == 1) ? md_data : ld_data;
    @(posedge clk);
    if (rst) begin
      m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0; m_busy = 32'd0; m_last = 2;
      last_g = -1;
    end else begin
      m_we = (g >= 0) && (a != 5'd0);
      if (g >= 0) begin
        m_wa = a;
        m_wd = d;
      end
      if ((g == 1 || g == 2) && a != 5'd0) m_busy[a] = 1'b0;
      if (alloc_valid && alloc_addr != 5'd0) m_busy[alloc_addr] = 1'b1;
      if (g == 1 || g == 2) m_last = g;
      last_g = g;
    end
    #1;
    chk({tag, ".rf_we"}, {31'd0, rf_we}, {31'd0, m_we});
    chk({tag, ".rf_wa"}, {27'd0, rf_wa}, {27'd0, m_wa});
    chk({tag, ".rf_wd"}, rf_wd, m_wd);
    chk({tag, ".busy_mask"}, busy_mask, m_busy);
    $display("[%0t] %s grant=%0d rf_we=%0b rf_wa=%0d rf_wd=%h busy=%h", $time, tag, last_g, rf_we, rf_wa, rf_wd, busy_mask);
  endtask

  task automatic idle_inputs();
    wb_valid = 0; md_valid = 0; ld_valid = 0; alloc_valid = 0;
  endtask

  initial begin
    m_busy = 32'd0; m_we = 0; m_wa = 0; m_wd = 0; m_last = 2; last_g = -1;
    qa1 = 0; qa2 = 0; alloc_addr = 0;
    wb_addr = 1; wb_data = 32'h1; md_addr = 2; md_data = 32'h2; ld_addr = 4; ld_data = 32'h4;

    // Reset with every requester active: nothing written, scoreboard stays empty.
    rst = 1; wb_valid = 1; md_valid = 1; ld_valid = 1; alloc_valid = 1; alloc_addr = 6;
    step("reset0");
    step("reset1");
    chk("reset.rf_we_abs", {31'd0, rf_we}, 32'd0);
    chk("reset.busy_abs", busy_mask, 32'd0);
    rst = 0; idle_inputs();
    step("idle");

    // Pipeline WB beats mul/div; the md write follows a cycle later.
    wb_valid = 1; wb_addr = 3; wb_data = 32'hAAAA0001;
    md_valid = 1; md_addr = 5; md_data = 32'h5555_0005;
    step("prio.wb");
    chk("prio.rf_wa_abs", {27'd0, rf_wa}, 32'd3);
    chk("prio.rf_wd_abs", rf_wd, 32'hAAAA0001);
    wb_valid = 0;
    step("prio.md");
    chk("prio.md_wa_abs", {27'd0, rf_wa}, 32'd5);
    md_valid = 0;

    // Long-latency op on r7: busy until the md write commits.
    alloc_valid = 1; alloc_addr = 7; qa1 = 7; qa2 = 0;
    step("sb.alloc");
    alloc_valid = 0;
    for (int i = 0; i < 10; i++) begin
      step("sb.wait");
      chk("sb.busy1_held", {31'd0, busy1}, 32'd1);
    end
    md_valid = 1; md_addr = 7; md_data = 32'h12345678;
    step("sb.commit");
    chk("sb.busy1_low", {31'd0, busy1}, 32'd0);
    chk("sb.commit_wd", rf_wd, 32'h12345678);
    md_valid = 0;

    // Same-edge alloc and clear of r9: alloc wins.
    alloc_valid = 1; alloc_addr = 9;
    step("same.alloc");
    md_valid = 1; md_addr = 9; md_data = 32'h9999_0009;
    step("same.both");
    chk("same.bit9", {31'd0, busy_mask[9]}, 32'd1);
    idle_inputs();

    // Load to r0: handshake completes but nothing is written.
    ld_valid = 1; ld_addr = 0; ld_data = 32'hDEAD_0000;
    step("addr0");
    chk("addr0.rf_we_abs", {31'd0, rf_we}, 32'd0);
    ld_valid = 0;

    // Contention: md and ld both keep requesting, re-presenting after each accept.
    md_valid = 1; md_addr = 10; ld_valid = 1; ld_addr = 11;
    grants.delete();
    for (int i = 0; i < 4; i++) begin
      md_data = 32'hC0DE_0000 + i; ld_data = 32'hF00D_0000 + i;
      step("contend");
      grants.push_back(last_g);
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
`ifdef RF_WB_RR_EN
      chk("contend.order", grants[i], (i % 2 == 0) ? 1 : 2);
`else
      chk("contend.order", grants[i], 1);
`endif
    end

    // Randomized traffic honouring the hold-until-ready protocol, with one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      rst = (i == 200) || (i == 201);
      wb_valid = (($urandom % 8) < 5) && (i % 8 != 7);
      wb_addr = 5'($urandom); wb_data = $urandom;
      alloc_valid = ($urandom % 4) == 0; alloc_addr = 5'($urandom);
      qa1 = 5'($urandom); qa2 = 5'($urandom);
      if (!md_valid) begin
        md_valid = ($urandom % 2) == 1; md_addr = 5'($urandom); md_data = $urandom;
      end
      if (!ld_valid) begin
        ld_valid = ($urandom % 2) == 1; ld_addr = 5'($urandom); ld_data = $urandom;
      end
      step("rand");
      if (last_g == 1) md_valid = 0;
      if (last_g == 2) ld_valid = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
